// File: rtl/gnn_aggr.sv
// gnn_aggr: neighbour-aggregation stage for the GNN layer.
//
// Sums up to MAX_NBR per-node ReLU feature vectors (four lanes, FEAT_W bits
// each) element-wise and presents the AGGR_W-bit aggregated vector to the
// output layer together with a single-cycle aggr_valid pulse.
//
// Ports:
//   clk         clock, rising-edge active
//   rst         asynchronous, active-high reset
//   start       single-cycle pulse, begins (or restarts) an aggregation
//   nbr_cnt     number of vectors to sum, sampled when start=1
//   in_valid    a feature vector is present on y4_relu..y7_relu
//   y4..y7_relu signed ReLU features of one node
//   in_ready    high while vectors are being accepted
//   busy        high while an aggregation is in progress
//   y4..y7_aggr registered aggregated features, held until next completion
//   aggr_valid  one-cycle pulse when y*_aggr update
//
// Optional feature macro: GNN_AGGR_SAT_EN
//   defined   - each accumulator saturates at 2^(AGGR_W-1)-1
//   undefined - accumulators wrap modulo 2^AGGR_W
module gnn_aggr #(
  parameter int MAX_NBR = 4,
  parameter int FEAT_W  = 15,
  parameter int AGGR_W  = 17,
  localparam int CNT_W  = $clog2(MAX_NBR + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         nbr_cnt,
  input  logic                     in_valid,
  input  logic signed [FEAT_W-1:0] y4_relu,
  input  logic signed [FEAT_W-1:0] y5_relu,
  input  logic signed [FEAT_W-1:0] y6_relu,
  input  logic signed [FEAT_W-1:0] y7_relu,
  output logic                     in_ready,
  output logic                     busy,
  output logic signed [AGGR_W-1:0] y4_aggr,
  output logic signed [AGGR_W-1:0] y5_aggr,
  output logic signed [AGGR_W-1:0] y6_aggr,
  output logic signed [AGGR_W-1:0] y7_aggr,
  output logic                     aggr_valid
);

  typedef enum logic {IDLE, ACCUM} state_t;

`ifdef GNN_AGGR_SAT_EN
  localparam logic [AGGR_W-1:0] SAT_MAX = {1'b0, {(AGGR_W-1){1'b1}}};
`endif

  state_t                  state, next_state;
  logic [3:0][FEAT_W-1:0]  feat;
  logic [3:0][AGGR_W-1:0]  acc;
  logic [3:0][AGGR_W-1:0]  sum;
  logic [3:0][AGGR_W-1:0]  result;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        target;
  logic [CNT_W-1:0]        target_in;
  logic                    last;

  // A feature with its sign bit set contributes nothing; otherwise it is
  // zero-extended into the accumulator width.
  function automatic logic [AGGR_W-1:0] relu(input logic [FEAT_W-1:0] f);
    relu = f[FEAT_W-1] ? '0 : AGGR_W'(f);
  endfunction

  // One lane of accumulation. The saturating variant relies on both
  // operands being non-negative, which holds because relu() never emits a
  // negative value and the accumulator is clamped below the sign bit.
  function automatic logic [AGGR_W-1:0] add_lane(input logic [AGGR_W-1:0] a,
                                                 input logic [AGGR_W-1:0] b);
`ifdef GNN_AGGR_SAT_EN
    logic [AGGR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, SAT_MAX}) add_lane = SAT_MAX;
    else add_lane = s[AGGR_W-1:0];
`else
    add_lane = a + b;
`endif
  endfunction

  assign feat = {y7_relu, y6_relu, y5_relu, y4_relu};

  // Requests above MAX_NBR are clamped so the counter can always reach them.
  assign target_in = (nbr_cnt > CNT_W'(MAX_NBR)) ? CNT_W'(MAX_NBR) : nbr_cnt;

  // The vector currently presented is the final one of this aggregation.
  assign last = ((count + CNT_W'(1)) == target);

  assign y4_aggr = result[0];
  assign y5_aggr = result[1];
  assign y6_aggr = result[2];
  assign y7_aggr = result[3];

  // Per-lane running sum including the vector on the inputs this cycle.
  always_comb begin
    sum = '0;
    for (int k = 0; k < 4; k++) begin
      sum[k] = add_lane(acc[k], relu(feat[k]));
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and status outputs. start outranks in_valid everywhere, and
  // a zero-length request completes straight from IDLE without entering
  // ACCUM.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start && (target_in != '0)) next_state = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (start) next_state = (target_in == '0) ? IDLE : ACCUM;
        else if (in_valid && last) next_state = IDLE;
      end
    endcase
  end

  // Datapath: accumulators, counter, target and the registered result.
  // The final vector is folded in on the completing edge so aggr_valid
  // appears in the cycle right after the last in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      count      <= '0;
      target     <= '0;
      result     <= '0;
      aggr_valid <= 1'b0;
    end else begin
      aggr_valid <= 1'b0;
      if (start) begin
        acc    <= '0;
        count  <= '0;
        target <= target_in;
        if (target_in == '0) begin
          result     <= '0;
          aggr_valid <= 1'b1;
        end
      end else if ((state == ACCUM) && in_valid) begin
        if (last) begin
          result     <= sum;
          aggr_valid <= 1'b1;
          acc        <= '0;
          count      <= '0;
        end else begin
          acc   <= sum;
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/gnn_aggr.md
Name: gnn_aggr

Overview:
- Neighbour-aggregation stage for the GNN layer.
- Takes the per-node ReLU feature vectors (four 15-bit features) that each dense/GNN node produces, one vector per cycle, and sums them element-wise over a programmable neighbour count.
- Returns the 17-bit aggregated vector that feeds the second (output) layer, with a one-cycle valid pulse.
- Sits between the hidden-layer ReLU outputs and the output-layer aggregated inputs.

Parameters:
- MAX_NBR, 4, maximum neighbour vectors per aggregation; sizes nbr_cnt and the internal counter.
- FEAT_W, 15, signed width of each incoming ReLU feature.
- AGGR_W, 17, signed width of each aggregated output feature.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle pulse; begins a new aggregation and clears the accumulators.
- nbr_cnt  input  $clog2(MAX_NBR+1)  number of vectors to sum; sampled only when start=1.
- in_valid  input  1  a feature vector is presented on y4_relu..y7_relu.
- y4_relu, y5_relu, y6_relu, y7_relu  input  FEAT_W each  signed ReLU features of one node.
- in_ready  output  1  high while the block accepts vectors (ACCUM state).
- busy  output  1  high from the cycle after start until aggr_valid is asserted.
- y4_aggr, y5_aggr, y6_aggr, y7_aggr  output  AGGR_W each  registered aggregated features; held until the next completion.
- aggr_valid  output  1  one-cycle pulse when the y*_aggr outputs update.

Behaviour:
- Reset: state=IDLE; accumulators, counter, target=0; y*_aggr=0; aggr_valid=0; in_ready=0; busy=0. Reset is asynchronous and overrides everything, including mid-aggregation; the partial sum is discarded.
- States: IDLE, ACCUM.
- IDLE:
  - in_valid is ignored.
  - start=1 latches target=min(nbr_cnt, MAX_NBR), clears accumulators and counter, and moves to ACCUM.
  - Exception: if target=0, stay in IDLE and next cycle drive y*_aggr=0 with aggr_valid=1.
- ACCUM:
  - in_ready=busy=1.
  - Each cycle with in_valid=1: acc_k += relu(y_k_relu), counter++.
  - relu(): a feature with its sign bit set contributes 0 (defensive ReLU). Otherwise the value is zero-extended to AGGR_W.
  - When the accepted vector is the target-th one: y*_aggr <= acc+input, aggr_valid <= 1 on that same edge, and the state returns to IDLE.
  - Latency: aggr_valid is high in the cycle immediately after the final in_valid cycle.
- start during ACCUM: the aggregation restarts. Accumulators and counter clear, target is re-latched, and any in_valid in that cycle is dropped. start has priority over in_valid in every state.
- aggr_valid is a single-cycle pulse. y*_aggr hold their value until the next completion and do not change on start.
- Width: with FEAT_W=15 and MAX_NBR=4 the maximum sum is 4*16383=65532, which fits in AGGR_W=17 signed. Overflow is only possible with larger parameters; see the optional feature.
- No back-pressure on the output: the consumer must sample y*_aggr on or after aggr_valid.

Optional Feature:
- Macro: GNN_AGGR_SAT_EN.
- Defined: each accumulator saturates at 2^(AGGR_W-1)-1 (65535 for the defaults). Once saturated it stays there until cleared, and outputs are never negative.
- Undefined: accumulators wrap modulo 2^AGGR_W with no saturation logic. An overflowed result may read as negative.

Test Plan:
- Reset, then start with nbr_cnt=2; vectors (10,20,30,40) and (1,2,3,4) on consecutive cycles -> aggr_valid exactly one cycle after the 2nd vector; y4..y7_aggr=(11,22,33,44); busy and in_ready drop in the same cycle.
- nbr_cnt=4 with in_valid gaps (vectors on cycles 1,3,4,7), each vector all 16383 -> outputs 65532 on all four lanes, aggr_valid on cycle 8.
- Vector containing a negative feature (y5_relu=-5, others 7), nbr_cnt=1 -> y*_aggr=(7,0,7,7).
- start with nbr_cnt=3, accept 2 vectors, re-assert start with nbr_cnt=1 while in_valid=1 -> that vector is dropped; the next vector (5,5,5,5) alone yields (5,5,5,5).
- nbr_cnt=0 -> aggr_valid the cycle after start, outputs 0. nbr_cnt=7 with MAX_NBR=4 -> completes after 4 vectors.
- Assert rst asynchronously mid-ACCUM -> all outputs 0 immediately and no aggr_valid. With GNN_AGGR_SAT_EN and MAX_NBR=8 plus eight vectors of 16383 -> each lane 65535; without the macro -> wrapped value 131064 mod 131072 = 131064 (reads as -8).
